key_num_entry: RTL

Numeric entry stage directly downstream of the keypad front end. Consumes the one-cycle key-valid strobe and 5-bit key code and accumulates decimal digits into an edit buffer. On ENTER it converts the buffer to binary, range-checks it, and publishes a committed parameter value (e.g. a threshold or brightness offset) to the image-processing datapath, with a one-cycle update strobe. Also exports the edit buffer for the 7-segment display.

---
 rtl/key_num_entry_pkg.sv | 49 ++++
 rtl/key_num_entry_bcd_to_bin.sv | 43 ++++
 rtl/key_num_entry.sv | 135 +++++++++++++
 3 files changed

// File: rtl/key_num_entry_pkg.sv
// Shared key codes, display blank value and helpers for the numeric entry stage.
// The 7-segment display driver uses the same constants.
package key_num_entry_pkg;

  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_CLR       = 5'd10;
  localparam logic [4:0] KEY_ENTER     = 5'd11;
  localparam logic [4:0] KEY_BKSP      = 5'd12;
  localparam logic [3:0] BLANK         = 4'hF;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_DIGIT,
    KC_CLR,
    KC_ENTER,
    KC_BKSP
  } key_class_e;

  // Codes 13..31 fall through to KC_NONE and are ignored everywhere.
  function automatic key_class_e classify_key(input logic valid, input logic [4:0] code);
    key_class_e kc;
    kc = KC_NONE;
    if (valid) begin
      if (code <= KEY_DIGIT_MAX)  kc = KC_DIGIT;
      else if (code == KEY_CLR)   kc = KC_CLR;
      else if (code == KEY_ENTER) kc = KC_ENTER;
      else if (code == KEY_BKSP)  kc = KC_BKSP;
    end
    return kc;
  endfunction

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Bits needed to hold 10^digits, e.g. 10 for three digits.
  function automatic int bin_width(input int digits);
    int w;
    int p;
    p = pow10(digits);
    w = 0;
    while ((64'd1 << w) < 64'(p)) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_num_entry_bcd_to_bin.sv
// Converts the low i_cnt BCD digits of the edit buffer to binary; the result
// is registered when i_en is high.
module key_num_entry_bcd_to_bin
  import key_num_entry_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = bin_width(DIGITS)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [2:0]            i_cnt,
  output logic [BIN_W-1:0]      o_bin
);

  logic [BIN_W-1:0] w_term [DIGITS];
  logic [BIN_W-1:0] w_sum;
  logic [BIN_W-1:0] r_bin;

  // Blank nibbles above the entered digits are masked out by the count.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_term
      assign w_term[gi] = (i_cnt > 3'(gi))
                        ? BIN_W'(i_bcd[4*gi +: 4]) * BIN_W'(pow10(gi))
                        : '0;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < DIGITS; k++) w_sum = w_sum + w_term[k];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn)   r_bin <= '0;
    else if (i_en) r_bin <= w_sum;
  end

  assign o_bin = r_bin;

endmodule

// File: rtl/key_num_entry.sv
// Numeric entry stage: accumulates decimal key digits into an edit buffer and,
// on ENTER, converts, range-checks and publishes a committed value.
module key_num_entry
  import key_num_entry_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int VAL_W   = 8,
  parameter int MAX_VAL = 255,
  parameter int RST_VAL = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_key_valid,
  input  logic [4:0]            i_bcd_data,
  output logic [4*DIGITS-1:0]   o_disp_bcd,
  output logic [2:0]            o_disp_cnt,
  output logic                  o_editing,
  output logic                  o_busy,
  output logic [VAL_W-1:0]      o_value,
  output logic                  o_value_vld,
  output logic                  o_err
);

  localparam int BUF_W = 4 * DIGITS;
  localparam int BIN_W = bin_width(DIGITS);
  localparam logic [BUF_W-1:0] BLANK_BUF = {DIGITS{BLANK}};
  localparam logic [2:0]       CNT_MAX   = 3'(DIGITS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EDIT   = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]       r_state;
  logic [BUF_W-1:0] r_buf;
  logic [2:0]       r_cnt;
  logic [VAL_W-1:0] r_value;
  logic             r_value_vld;
  logic             r_err;

  key_class_e       w_key;
  logic [3:0]       w_digit;
  logic [BUF_W-1:0] w_buf_first;
  logic [BUF_W-1:0] w_buf_push;
  logic [BUF_W-1:0] w_buf_pop;
  logic [BIN_W-1:0] w_bin;
  logic             w_in_range;

  assign w_key       = classify_key(i_key_valid, i_bcd_data);
  assign w_digit     = i_bcd_data[3:0];
  assign w_buf_first = (BLANK_BUF << 4) | BUF_W'(w_digit);
  assign w_buf_push  = (r_buf << 4) | BUF_W'(w_digit);
  assign w_buf_pop   = (r_buf >> 4) | (BUF_W'(BLANK) << (BUF_W - 4));
  assign w_in_range  = 32'(w_bin) <= 32'(MAX_VAL);

  key_num_entry_bcd_to_bin #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_bcd_to_bin (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (r_state == S_CONV),
    .i_bcd  (r_buf),
    .i_cnt  (r_cnt),
    .o_bin  (w_bin)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_buf       <= BLANK_BUF;
      r_cnt       <= '0;
      r_value     <= VAL_W'(RST_VAL);
      r_value_vld <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_value_vld <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_key == KC_DIGIT) begin
            r_buf   <= w_buf_first;
            r_cnt   <= 3'd1;
            r_state <= S_EDIT;
          end
        end
        S_EDIT: begin
          case (w_key)
            KC_DIGIT: begin
              // A full buffer ignores further digits rather than wrapping.
              if (r_cnt < CNT_MAX) begin
                r_buf <= w_buf_push;
                r_cnt <= r_cnt + 3'd1;
              end
            end
            KC_BKSP: begin
              r_buf <= w_buf_pop;
              r_cnt <= r_cnt - 3'd1;
              if (r_cnt == 3'd1) r_state <= S_IDLE;
            end
            KC_CLR: begin
              r_buf   <= BLANK_BUF;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
            KC_ENTER: r_state <= S_CONV;
            default: ;
          endcase
        end
        S_CONV: r_state <= S_COMMIT;
        S_COMMIT: begin
          if (w_in_range) begin
            r_value     <= VAL_W'(w_bin);
            r_value_vld <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_buf   <= BLANK_BUF;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_disp_bcd  = r_buf;
  assign o_disp_cnt  = r_cnt;
  assign o_editing   = (r_cnt != 3'd0);
  assign o_busy      = (r_state == S_CONV) || (r_state == S_COMMIT);
  assign o_value     = r_value;
  assign o_value_vld = r_value_vld;
  assign o_err       = r_err;

endmodule
